seg7_scan_mux: RTL and testbench
================================

# seg7_scan_mux

Parametrised multiplexed 7-segment display driver, the successor to the fixed 8-digit decimal scanner. It drives NUM_DIGITS common-anode/cathode digits from a shared segment bus and decodes full hex (0–F). It adds per-digit decimal points, optional leading-zero blanking, PWM brightness and inter-digit dead time. New display data is loaded through a valid/ready handshake and committed only at frame boundaries, so a frame never shows a mix of old and new data. It sits between the value-producing logic (counters, timers) and the board's LED pins.

## Interface
Parameters:
- NUM_DIGITS, 8, number of digits scanned (2–16)
- CLK_DIV, 25000, clock cycles per digit slot (≥ DEAD_CYCLES+2)
- DEAD_CYCLES, 2, cycles at the start of each slot with all digits off (anti-ghosting)
- BRIGHT_BITS, 4, width of brightness control and PWM counter
- SEG_ACTIVE_LOW, 1, 1 = segment lit when pin low
- DIG_ACTIVE_LOW, 1, 1 = digit enabled when pin low

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- load_valid  in  1  new display data offered
- load_ready  out  1  block can accept data
- load_data  in  4*NUM_DIGITS  hex nibble per digit; nibble d = digit d (digit 0 least significant)
- load_dp  in  NUM_DIGITS  decimal point per digit, 1 = lit
- lzb_en  in  1  leading-zero blanking enable (sampled live)
- brightness  in  BRIGHT_BITS  duty control (sampled live)
- units  out  NUM_DIGITS  digit enables, polarity per DIG_ACTIVE_LOW
- segments  out  8  [0]=a … [6]=g, [7]=dp, polarity per SEG_ACTIVE_LOW

## Operation
- Prescaler `pre` counts 0..CLK_DIV-1. Slot tick when pre==CLK_DIV-1: pre→0 and digit index `idx`→idx+1, wrapping NUM_DIGITS-1→0.
- Frame end is the slot tick with idx==NUM_DIGITS-1.
- PWM counter `pwm` is a free-running BRIGHT_BITS counter, +1 every clock with wrap.
  - PWM on iff pwm < brightness, or brightness == all-ones (100%).
  - brightness 0 = dark.
- Leading-zero blanking:
  - When lzb_en=1, digit d is blanked if its active nibble is 0, its dp is 0, and every digit above d is also blanked.
  - Digit 0 is never blanked.
- Digit d is driven iff d==idx, pre ≥ DEAD_CYCLES, PWM on, and d is not blanked.
- When no digit is driven, units and segments are all inactive.
- Hex decode for a..g (lit set): 0:abcdef, 1:bc, 2:abdeg, 3:abcdg, 4:bcfg, 5:acdfg, 6:acdefg, 7:abc, 8:all, 9:abcdfg, A:abcefg, b:cdefg, C:adef, d:bcdeg, E:adefg, F:aefg. dp comes from the active dp bit.
- Load FSM:
  - IDLE: load_ready=1. valid&ready captures load_data/load_dp into the pending register → PENDING.
  - PENDING: load_ready=0. At frame end, pending → active → IDLE.
- Reset values: units all inactive (all 1 when DIG_ACTIVE_LOW=1); segments all off (8'hFF when SEG_ACTIVE_LOW=1); load_ready=1; FSM=IDLE; active and pending data 0; pre, idx, pwm = 0.

## Timing
- units and segments are registered: they reflect pre/idx/pwm/active state of the previous cycle (1-cycle latency).
- With brightness at 100%, each digit is driven for CLK_DIV-DEAD_CYCLES consecutive cycles per slot. Frame period is NUM_DIGITS*CLK_DIV cycles.
- Accept at edge E → load_ready=0 from E onward. The commit edge is the first frame end strictly after E. load_ready=1 from the commit edge.
- Valid in IDLE on the frame-end edge itself: data is accepted, but the commit waits for the following frame end (one full frame later).
- The commit edge coincides with idx wrapping to 0, so digit 0 of the new frame shows the new data.
- load_valid while PENDING is ignored; the data is not captured.
- lzb_en and brightness take effect on the next registered output.
- Reset asserted at any time: all outputs take reset values immediately (async). A pending load is discarded.

## Test plan
Use NUM_DIGITS=4, CLK_DIV=8, DEAD_CYCLES=2, BRIGHT_BITS=4, both polarities active-low.
- **Reset:** assert reset mid-slot → units=4'b1111, segments=8'hFF, load_ready=1 in the same cycle. Release → first frame shows digit 0 as 8'hC0 ("0").
- **Load and commit:** brightness=4'hF, load 16'h1A3F with dp=4'b0100 in frame N.
  - load_ready low until the frame-N end edge.
  - Next frame: digit0 F=8'h8E, digit1 3=8'hB0, digit2 A with dp=8'h08, digit3 1=8'hF9.
  - Each digit's unit is active for 6 of 8 slot cycles.
- **Frame-end collision:** valid asserted exactly on the frame-end edge → accepted, committed one frame (32 cycles) later. A second valid while PENDING is ignored and the display shows the first data.
- **Leading-zero blanking:** lzb_en=1, data 16'h0050, dp=0 → digits 3 and 2 dark (units never active); digits 1 and 0 show 5 and 0. With dp[3]=1, digit 3 shows 0 with dp (8'h40).
- **Brightness:**
  - brightness=4 → within any 16-cycle window of a driven slot, units active only where pwm<4.
  - brightness=0 → units stays 4'b1111.
- **Reset during PENDING:** accept a load, assert reset before frame end → after release the display shows all zeros and load_ready=1.

Source files
------------

// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: multiplexed 7-segment display driver.
//
// The block scans NUM_DIGITS digits over one shared segment bus and decodes
// hex digits 0-F. It also provides per-digit decimal points, optional
// leading-zero blanking, PWM brightness control, and a dead time at the start
// of each digit slot. New data is taken through a valid/ready handshake and is
// copied into the displayed set only at a frame boundary. Because of this, one
// frame never shows a mix of old and new data.
//
// Ports:
//   clock       system clock
//   reset       asynchronous, active-high reset
//   load_valid  new display data is offered
//   load_ready  the block can accept data (idle, with no load pending)
//   load_data   one hex nibble per digit; nibble d is digit d (digit 0 = LSD)
//   load_dp     decimal point for each digit, 1 = lit
//   lzb_en      leading-zero blanking enable, sampled live
//   brightness  PWM duty control (all-ones = 100 %, 0 = dark), sampled live
//   units       digit enables, polarity set by DIG_ACTIVE_LOW
//   segments    {dp,g,f,e,d,c,b,a}, polarity set by SEG_ACTIVE_LOW
module seg7_scan_mux #(
  parameter int unsigned NUM_DIGITS     = 8,
  parameter int unsigned CLK_DIV        = 25000,
  parameter int unsigned DEAD_CYCLES    = 2,
  parameter int unsigned BRIGHT_BITS    = 4,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic [NUM_DIGITS-1:0]   load_dp,
  input  logic                    lzb_en,
  input  logic [BRIGHT_BITS-1:0]  brightness,
  output logic [NUM_DIGITS-1:0]   units,
  output logic [7:0]              segments
);

  localparam int unsigned PreW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [PreW-1:0]       PreLast  = PreW'(CLK_DIV - 1);
  localparam logic [PreW-1:0]       PreDead  = PreW'(DEAD_CYCLES);
  localparam logic [IdxW-1:0]       IdxLast  = IdxW'(NUM_DIGITS - 1);
  // Levels that mean "off" on the pins. XOR with these converts an
  // active-high value into the polarity of the pin.
  localparam logic [NUM_DIGITS-1:0] UnitsOff = {NUM_DIGITS{DIG_ACTIVE_LOW}};
  localparam logic [7:0]            SegOff   = {8{SEG_ACTIVE_LOW}};

  typedef enum logic [0:0] {
    StIdle,
    StPending
  } load_state_e;

  // Hex decode to the lit segments, with bit 0 = a and bit 6 = g.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    unique case (nib)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
      default: seg = 7'h00;
    endcase
    return seg;
  endfunction

  // ---------------------------------------------------------------------------
  // Scan timing: prescaler, digit index and free-running PWM counter
  // ---------------------------------------------------------------------------
  logic [PreW-1:0]        pre_q, pre_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic [BRIGHT_BITS-1:0] pwm_q, pwm_d;
  logic                   slot_tick;
  logic                   frame_end;

  assign slot_tick = (pre_q == PreLast);
  assign frame_end = slot_tick && (idx_q == IdxLast);
  assign pwm_d     = pwm_q + BRIGHT_BITS'(1);

  always_comb begin
    pre_d = pre_q + PreW'(1);
    idx_d = idx_q;
    if (slot_tick) begin
      pre_d = '0;
      idx_d = (idx_q == IdxLast) ? '0 : idx_q + IdxW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pre_q <= '0;
      idx_q <= '0;
      pwm_q <= '0;
    end else begin
      pre_q <= pre_d;
      idx_q <= idx_d;
      pwm_q <= pwm_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Load handshake. Accepted data waits in the pending register and is moved
  // to the active register on the next frame-end tick. That tick is the same
  // edge on which idx wraps to 0, so the new frame starts with the new data.
  // ---------------------------------------------------------------------------
  load_state_e             state_q, state_d;
  logic [4*NUM_DIGITS-1:0] pend_data_q, pend_data_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic [4*NUM_DIGITS-1:0] act_data_q, act_data_d;
  logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;

  always_comb begin
    state_d     = state_q;
    pend_data_d = pend_data_q;
    pend_dp_d   = pend_dp_q;
    act_data_d  = act_data_q;
    act_dp_d    = act_dp_q;
    load_ready  = 1'b0;
    unique case (state_q)
      StIdle: begin
        load_ready = 1'b1;
        // A frame end seen in this state does not commit anything. Data
        // accepted on a frame-end edge therefore waits a full frame.
        if (load_valid) begin
          pend_data_d = load_data;
          pend_dp_d   = load_dp;
          state_d     = StPending;
        end
      end
      StPending: begin
        if (frame_end) begin
          act_data_d = pend_data_q;
          act_dp_d   = pend_dp_q;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      pend_data_q <= '0;
      pend_dp_q   <= '0;
      act_data_q  <= '0;
      act_dp_q    <= '0;
    end else begin
      state_q     <= state_d;
      pend_data_q <= pend_data_d;
      pend_dp_q   <= pend_dp_d;
      act_data_q  <= act_data_d;
      act_dp_q    <= act_dp_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Leading-zero blanking. A digit is blanked only when every digit above it
  // is blanked too, so the scan runs from the most significant digit down.
  // ---------------------------------------------------------------------------
  logic [NUM_DIGITS-1:0] blank;
  logic                  above;

  always_comb begin
    blank = '0;
    above = 1'b1;
    for (int d = NUM_DIGITS - 1; d >= 1; d--) begin
      blank[d] = lzb_en && above && (act_data_q[4*d +: 4] == 4'h0) && !act_dp_q[d];
      above    = blank[d];
    end
  end

  // ---------------------------------------------------------------------------
  // Output selection and registered pin drive
  // ---------------------------------------------------------------------------
  logic [NUM_DIGITS-1:0] onehot;
  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic                  cur_blank;
  logic                  pwm_on;
  logic                  drive;
  logic [NUM_DIGITS-1:0] units_d;
  logic [7:0]            seg_d;

  always_comb begin
    onehot    = '0;
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (idx_q == IdxW'(d)) begin
        onehot[d] = 1'b1;
        cur_nib   = act_data_q[4*d +: 4];
        cur_dp    = act_dp_q[d];
        cur_blank = blank[d];
      end
    end
  end

  // All-ones brightness is a special case. Without it, pwm < brightness would
  // be false for one cycle in every PWM period.
  assign pwm_on = (brightness == {BRIGHT_BITS{1'b1}}) || (pwm_q < brightness);
  assign drive  = (pre_q >= PreDead) && pwm_on && !cur_blank;

  always_comb begin
    units_d = UnitsOff;
    seg_d   = SegOff;
    if (drive) begin
      units_d = onehot ^ UnitsOff;
      seg_d   = {cur_dp, hex_to_seg(cur_nib)} ^ SegOff;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      units    <= UnitsOff;
      segments <= SegOff;
    end else begin
      units    <= units_d;
      segments <= seg_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Directed bench for seg7_scan_mux. Parameters: 4 digits, 8 cycles per slot,
// 2 dead cycles, 4-bit brightness, active-low pins.
// cyc counts the clock edges since reset was released. At the negedge after
// edge k, the registered outputs show the scan state that held after edge k-1:
// pre=(k-1)%8, idx=((k-1)/8)%4, pwm=(k-1)%16. Frame-end edges are k = 32, 64, ...
module tb_seg7_scan_mux;
  localparam int unsigned NumDigits = 4;

  logic                     clock;
  logic                     reset = 1'b1;
  logic                     load_valid;
  logic                     load_ready;
  logic [4*NumDigits-1:0]   load_data;
  logic [NumDigits-1:0]     load_dp;
  logic                     lzb_en;
  logic [3:0]               brightness;
  logic [NumDigits-1:0]     units;
  logic [7:0]               segments;

  int total = 0;
  int bad   = 0;
  int cyc;
  int cnt [NumDigits];

  seg7_scan_mux #(
    .NUM_DIGITS    (NumDigits),
    .CLK_DIV       (8),
    .DEAD_CYCLES   (2),
    .BRIGHT_BITS   (4),
    .SEG_ACTIVE_LOW(1'b1),
    .DIG_ACTIVE_LOW(1'b1)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .load_data (load_data),
    .load_dp   (load_dp),
    .lzb_en    (lzb_en),
    .brightness(brightness),
    .units     (units),
    .segments  (segments)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Return at the negedge that follows edge n.
  task automatic wait_cyc(input int n);
    int guard = 0;
    while (cyc < n && guard < 2000) begin
      @(negedge clock);
      guard++;
    end
    if (cyc != n) check_eq("wait_cyc", cyc, n);
  endtask

  // Assert reset in the middle of a cycle, check the outputs at once, then
  // release reset at a negedge. After this, cyc == 0.
  task automatic pulse_reset(input string tag);
    reset = 1'b1;
    #1;
    check_eq({tag, "_units"}, units, 4'b1111);
    check_eq({tag, "_seg"}, segments, 8'hFF);
    check_eq({tag, "_ready"}, load_ready, 1'b1);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Count, for each digit, the samples in which its enable is active. The
  // count covers the 32 samples that start at sample `first`.
  task automatic count_frame(input int first);
    for (int d = 0; d < NumDigits; d++) cnt[d] = 0;
    for (int k = first; k < first + 32; k++) begin
      wait_cyc(k);
      for (int d = 0; d < NumDigits; d++) if (!units[d]) cnt[d]++;
    end
  endtask

  task automatic load(input logic [15:0] data, input logic [3:0] dp);
    load_valid = 1'b1;
    load_data  = data;
    load_dp    = dp;
  endtask

  initial begin
    logic [3:0] one;
    logic [3:0] exp_units;
    int s;
    one        = 4'b0001;
    load_valid = 1'b0;
    load_data  = '0;
    load_dp    = '0;
    lzb_en     = 1'b0;
    brightness = 4'hF;
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // Reset mid-slot while digit 1 is driven
    wait_cyc(13);
    check_eq("pre_rst_units", units, 4'b1101);
    check_eq("pre_rst_seg", segments, 8'hC0);
    pulse_reset("rst_mid");
    wait_cyc(1);
    check_eq("dead_units", units, 4'b1111);
    check_eq("dead_seg", segments, 8'hFF);
    wait_cyc(3);
    check_eq("first_units", units, 4'b1110);
    check_eq("first_seg", segments, 8'hC0);
    check_eq("first_ready", load_ready, 1'b1);

    // Load 1A3F with dp on digit 2 during frame 0; commit on edge 32
    wait_cyc(4);
    load(16'h1A3F, 4'b0100);
    wait_cyc(5);
    load_valid = 1'b0;
    check_eq("acc_ready", load_ready, 1'b0);
    wait_cyc(31);
    check_eq("pend_ready", load_ready, 1'b0);
    check_eq("old_units", units, 4'b0111);
    check_eq("old_seg", segments, 8'hC0);
    wait_cyc(32);
    check_eq("commit_ready", load_ready, 1'b1);
    count_frame(33);
    check_eq("on_cnt0", cnt[0], 6);
    check_eq("on_cnt1", cnt[1], 6);
    check_eq("on_cnt2", cnt[2], 6);
    check_eq("on_cnt3", cnt[3], 6);
    wait_cyc(68);
    check_eq("d0_units", units, 4'b1110);
    check_eq("d0_seg", segments, 8'h8E);
    wait_cyc(76);
    check_eq("d1_units", units, 4'b1101);
    check_eq("d1_seg", segments, 8'hB0);
    wait_cyc(84);
    check_eq("d2_units", units, 4'b1011);
    check_eq("d2_seg", segments, 8'h08);
    wait_cyc(92);
    check_eq("d3_units", units, 4'b0111);
    check_eq("d3_seg", segments, 8'hF9);

    // Valid on the frame-end edge 96: accepted, committed on edge 128
    wait_cyc(95);
    load(16'h4567, 4'b0000);
    wait_cyc(96);
    check_eq("fe_acc_ready", load_ready, 1'b0);
    load(16'h89AB, 4'b1111);  // offered while pending: must be ignored
    wait_cyc(100);
    load_valid = 1'b0;
    wait_cyc(127);
    check_eq("fe_wait_ready", load_ready, 1'b0);
    check_eq("fe_old_seg", segments, 8'hF9);
    wait_cyc(128);
    check_eq("fe_commit_ready", load_ready, 1'b1);
    wait_cyc(132);
    check_eq("fe_d0_units", units, 4'b1110);
    check_eq("fe_d0_seg", segments, 8'hF8);
    wait_cyc(140);
    check_eq("fe_d1_seg", segments, 8'h82);
    wait_cyc(156);
    check_eq("fe_d3_units", units, 4'b0111);
    check_eq("fe_d3_seg", segments, 8'h99);

    // Leading-zero blanking of 0050
    wait_cyc(160);
    lzb_en = 1'b1;
    load(16'h0050, 4'b0000);
    wait_cyc(161);
    load_valid = 1'b0;
    count_frame(193);
    check_eq("lzb_cnt0", cnt[0], 6);
    check_eq("lzb_cnt1", cnt[1], 6);
    check_eq("lzb_cnt2", cnt[2], 0);
    check_eq("lzb_cnt3", cnt[3], 0);
    wait_cyc(225);
    load(16'h0050, 4'b1000);
    wait_cyc(226);
    load_valid = 1'b0;
    wait_cyc(228);
    check_eq("lzb_d0_units", units, 4'b1110);
    check_eq("lzb_d0_seg", segments, 8'hC0);
    wait_cyc(236);
    check_eq("lzb_d1_seg", segments, 8'h92);
    wait_cyc(252);
    check_eq("lzb_d3_units", units, 4'b1111);
    check_eq("lzb_d3_seg", segments, 8'hFF);
    wait_cyc(276);
    check_eq("lzbdp_d2_units", units, 4'b1011);
    check_eq("lzbdp_d2_seg", segments, 8'hC0);
    wait_cyc(284);
    check_eq("lzbdp_d3_units", units, 4'b0111);
    check_eq("lzbdp_d3_seg", segments, 8'h40);

    // Brightness 4: a digit is driven only where pwm < 4 and the slot is past
    // its dead time
    wait_cyc(288);
    lzb_en     = 1'b0;
    brightness = 4'd4;
    for (int k = 289; k <= 320; k++) begin
      wait_cyc(k);
      s         = k - 1;
      exp_units = 4'b1111;
      if ((s % 8) >= 2 && (s % 16) < 4) exp_units = ~(one << ((s / 8) % 4));
      check_eq("bright4_units", units, exp_units);
    end
    brightness = 4'd0;
    for (int k = 321; k <= 352; k++) begin
      wait_cyc(k);
      check_eq("bright0_units", units, 4'b1111);
    end

    // Reset while a load is pending discards the load
    brightness = 4'hF;
    wait_cyc(354);
    load(16'h9999, 4'b1111);
    wait_cyc(355);
    load_valid = 1'b0;
    check_eq("rp_acc_ready", load_ready, 1'b0);
    wait_cyc(360);
    pulse_reset("rst_pend");
    wait_cyc(1);
    check_eq("rp_ready", load_ready, 1'b1);
    wait_cyc(3);
    check_eq("rp_d0_units", units, 4'b1110);
    check_eq("rp_d0_seg", segments, 8'hC0);
    wait_cyc(12);
    check_eq("rp_d1_units", units, 4'b1101);
    check_eq("rp_d1_seg", segments, 8'hC0);
    wait_cyc(28);
    check_eq("rp_d3_seg", segments, 8'hC0);
    wait_cyc(40);
    check_eq("rp_ready2", load_ready, 1'b1);
    wait_cyc(44);
    check_eq("rp_f1_d1_seg", segments, 8'hC0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
